// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the per-channel TMDS sequencer:
//   period_e  - symbol period classification (control / guard band / video)
//   CTRL_xx   - the four control-period code words, indexed by {c1,c0}
//   GUARD_*   - video guard-band code words (channels 0/2 and channel 1)
//   CNT_W     - width of the signed DC-balance disparity counter
//   dl_entry_t- one delay-line slot {de, ctrl, data}
//   enc_t     - video encoder result {symbol, next disparity}
// -----------------------------------------------------------------------------
package tmds_pkg;

   typedef enum logic [1:0] {
      PERIOD_CONTROL = 2'd0,
      PERIOD_GUARD   = 2'd1,
      PERIOD_VIDEO   = 2'd2
   } period_e;

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   localparam logic [9:0] GUARD_CH02 = 10'b1011001100;
   localparam logic [9:0] GUARD_CH1  = 10'b0100110011;

   localparam int CNT_W = 5;

   typedef struct packed {
      logic       de;
      logic [1:0] ctrl;
      logic [7:0] data;
   } dl_entry_t;

   typedef struct packed {
      logic [9:0]       sym;
      logic [CNT_W-1:0] cnt;
   } enc_t;

   function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = CTRL_00;
         2'b01:   s = CTRL_01;
         2'b10:   s = CTRL_10;
         default: s = CTRL_11;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/tm_choice.sv
// -----------------------------------------------------------------------------
// tm_choice
// Transition-minimizing stage of the TMDS video encoder. Chains the pixel bits
// with XOR or XNOR, whichever gives fewer transitions, and flags the choice.
// Ports:
//   data  in  8  pixel byte
//   q_m   out 9  transition-minimized word; q_m[8]=1 when XOR was used
// -----------------------------------------------------------------------------
module tm_choice (
   input  logic [7:0] data,
   output logic [8:0] q_m
);

   logic [3:0] n1;
   logic       use_xnor;
   logic [7:0] chain;

   always_comb begin
      n1 = '0;
      for (int i = 0; i < 8; i++) begin
         n1 = n1 + {3'b000, data[i]};
      end
      // XNOR when the byte is ones-heavy; on a 4/4 tie, bit 0 breaks it.
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
      chain    = '0;
      chain[0] = data[0];
      for (int i = 1; i < 8; i++) begin
         chain[i] = use_xnor ? ~(chain[i-1] ^ data[i]) : (chain[i-1] ^ data[i]);
      end
      q_m = {~use_xnor, chain};
   end

endmodule

// File: rtl/tmds_channel_sequencer.sv
// -----------------------------------------------------------------------------
// tmds_channel_sequencer
// Per-channel TMDS encoder controller. Each pixel clock emits one registered
// 10-bit symbol: a control code, a video guard-band code, or a DC-balanced
// video symbol. Inputs pass through a GUARD_LEN-deep delay line so the guard
// band can replace the last control symbols before each video period.
//
// Parameters:
//   CHANNEL    channel index 0..2 (selects guard-band code)
//   GUARD_LEN  guard-band length 0..4 (0 = plain DVI, no guard band)
// Ports:
//   clk_in      in  1   pixel clock
//   rst_n_in    in  1   asynchronous active-low reset
//   data_in     in  8   pixel byte, valid when de_in=1
//   control_in  in  2   {c1,c0}, used when de_in=0
//   de_in       in  1   data enable
//   bist_in     in  1   (TMDS_BIST_EN only) replace data_in with a ramp
//   tmds_out    out 10  encoded symbol, registered
//   period_out  out 2   0=CONTROL, 1=GUARD, 2=VIDEO for the symbol on tmds_out
//
// Build option: define TMDS_BIST_EN to add bist_in and the ramp generator.
// -----------------------------------------------------------------------------
module tmds_channel_sequencer
   import tmds_pkg::*;
#(
   parameter int CHANNEL   = 0,
   parameter int GUARD_LEN = 2
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [7:0] data_in,
   input  logic [1:0] control_in,
   input  logic       de_in,
`ifdef TMDS_BIST_EN
   input  logic       bist_in,
`endif
   output logic [9:0] tmds_out,
   output logic [1:0] period_out
);

   localparam logic [9:0] GUARD_SYM = (CHANNEL == 1) ? GUARD_CH1 : GUARD_CH02;

   logic [7:0]              byte_p0;
   dl_entry_t               entry_p0;
   dl_entry_t               head_p1;
   logic                    younger_de;
   period_e                 period_p1;
   logic [8:0]              q_m_p1;
   enc_t                    enc_p1;
   logic [9:0]              sym_p1;
   logic signed [CNT_W-1:0] cnt_q;
   logic signed [CNT_W-1:0] cnt_nxt;

   // DC balance against the running disparity. N1-N0 is formed as 2*N1-8.
   function automatic enc_t dc_balance(input logic [8:0] q_m,
                                       input logic signed [CNT_W-1:0] cnt_cur);
      enc_t                  r;
      logic [3:0]            n1;
      logic signed [CNT_W:0] diff;
      logic signed [CNT_W:0] acc;
      logic signed [CNT_W:0] two_q8;
      logic signed [CNT_W:0] two_nq8;
      logic                  cnt_zero;
      logic                  cnt_neg;
      logic                  cnt_pos;
      n1 = '0;
      for (int i = 0; i < 8; i++) begin
         n1 = n1 + {3'b000, q_m[i]};
      end
      diff     = $signed({1'b0, n1, 1'b0}) - 6'sd8;
      acc      = {cnt_cur[CNT_W-1], cnt_cur};
      two_q8   = q_m[8] ? 6'sd2 : 6'sd0;
      two_nq8  = q_m[8] ? 6'sd0 : 6'sd2;
      cnt_zero = (cnt_cur == '0);
      cnt_neg  = cnt_cur[CNT_W-1];
      cnt_pos  = !cnt_zero && !cnt_neg;
      if (cnt_zero || (diff == 6'sd0)) begin
         r.sym = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
         acc   = q_m[8] ? (acc + diff) : (acc - diff);
      end else if ((cnt_pos && (diff > 6'sd0)) || (cnt_neg && (diff < 6'sd0))) begin
         r.sym = {1'b1, q_m[8], ~q_m[7:0]};
         acc   = acc + two_q8 - diff;
      end else begin
         r.sym = {1'b0, q_m[8], q_m[7:0]};
         acc   = acc + diff - two_nq8;
      end
      r.cnt = acc[CNT_W-1:0];
      return r;
   endfunction

   // ---- stage p0: input byte selection -------------------------------------
`ifdef TMDS_BIST_EN
   logic [7:0] bist_cnt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bist_cnt <= '0;
      end else if (de_in) begin
         bist_cnt <= bist_cnt + 8'd1;
      end else begin
         bist_cnt <= '0;
      end
   end

   assign byte_p0 = bist_in ? bist_cnt : data_in;
`else
   assign byte_p0 = data_in;
`endif

   assign entry_p0 = '{de: de_in, ctrl: control_in, data: byte_p0};

   // ---- stage p1: delay line, oldest entry feeds the encoder ----------------
   generate
      if (GUARD_LEN > 0) begin : g_dl
         dl_entry_t dl_p1 [GUARD_LEN];

         always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
               for (int i = 0; i < GUARD_LEN; i++) begin
                  dl_p1[i] <= '0;
               end
            end else begin
               dl_p1[0] <= entry_p0;
               for (int i = 1; i < GUARD_LEN; i++) begin
                  dl_p1[i] <= dl_p1[i-1];
               end
            end
         end

         assign head_p1 = dl_p1[GUARD_LEN-1];

         // Video is coming if anything younger than the head is active.
         always_comb begin
            younger_de = de_in;
            for (int i = 0; i < GUARD_LEN - 1; i++) begin
               younger_de = younger_de | dl_p1[i].de;
            end
         end
      end else begin : g_no_dl
         assign head_p1    = entry_p0;
         assign younger_de = 1'b0;
      end
   endgenerate

   always_comb begin
      period_p1 = PERIOD_CONTROL;
      if (head_p1.de) begin
         period_p1 = PERIOD_VIDEO;
      end else if (younger_de) begin
         period_p1 = PERIOD_GUARD;
      end
   end

   tm_choice u_tm_choice (
      .data (head_p1.data),
      .q_m  (q_m_p1)
   );

   assign enc_p1 = dc_balance(q_m_p1, cnt_q);

   // Disparity restarts from zero after every non-video symbol.
   always_comb begin
      sym_p1  = ctrl_symbol(head_p1.ctrl);
      cnt_nxt = '0;
      case (period_p1)
         PERIOD_VIDEO: begin
            sym_p1  = enc_p1.sym;
            cnt_nxt = $signed(enc_p1.cnt);
         end
         PERIOD_GUARD: sym_p1 = GUARD_SYM;
         default: ;
      endcase
   end

   // ---- stage p2: output register ------------------------------------------
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tmds_out   <= CTRL_00;
         period_out <= PERIOD_CONTROL;
         cnt_q      <= '0;
      end else begin
         tmds_out   <= sym_p1;
         period_out <= period_p1;
         cnt_q      <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_tmds_channel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tmds_channel_sequencer
// Directed and random stimulus for two sequencer instances (CHANNEL 0 and 1,
// GUARD_LEN 2) driven from the same inputs.
// -----------------------------------------------------------------------------
module tb_tmds_channel_sequencer;

   localparam logic [9:0] S_C00 = 10'b1101010100;
   localparam logic [9:0] S_C01 = 10'b0010101011;
   localparam logic [9:0] S_C10 = 10'b0101010100;
   localparam logic [9:0] S_C11 = 10'b1010101011;
   localparam logic [9:0] S_G02 = 10'b1011001100;
   localparam logic [9:0] S_G1  = 10'b0100110011;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic [7:0] data_in;
   logic [1:0] control_in;
   logic       de_in;
`ifdef TMDS_BIST_EN
   logic       bist_in;
`endif
   logic [9:0] tmds0, tmds1;
   logic [1:0] per0, per1;

   int n_vec = 0;
   int n_err = 0;

   // history of applied inputs: index 0 = most recent edge
   logic       h_de   [3];
   logic [1:0] h_ctrl [3];
   logic [7:0] h_data [3];

   logic       cur_de;
   int         run_left;
   int         disp;
   logic [1:0] exp_per;

   always #5 clk_in = ~clk_in;

   tmds_channel_sequencer #(.CHANNEL(0), .GUARD_LEN(2)) dut0 (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .data_in    (data_in),
      .control_in (control_in),
      .de_in      (de_in),
`ifdef TMDS_BIST_EN
      .bist_in    (bist_in),
`endif
      .tmds_out   (tmds0),
      .period_out (per0)
   );

   tmds_channel_sequencer #(.CHANNEL(1), .GUARD_LEN(2)) dut1 (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .data_in    (data_in),
      .control_in (control_in),
      .de_in      (de_in),
`ifdef TMDS_BIST_EN
      .bist_in    (bist_in),
`endif
      .tmds_out   (tmds1),
      .period_out (per1)
   );

   function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = S_C00;
         2'b01:   s = S_C01;
         2'b10:   s = S_C10;
         default: s = S_C11;
      endcase
      return s;
   endfunction

   // TMDS receiver-side decode of a video symbol
   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d    = '0;
      d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
      return d;
   endfunction

   // ones minus zeros over the 10 transmitted bits
   function automatic int sym_disp(input logic [9:0] s);
      int n;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         n = n + (s[i] ? 1 : -1);
      end
      return n;
   endfunction

   task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %b, want %b", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
      n_vec++;
      assert (v >= lo && v <= hi) else begin
         n_err++;
         $error("FAIL %s: got %0d, want %0d..%0d", tag, v, lo, hi);
      end
   endtask

   task automatic clear_hist();
      for (int i = 0; i < 3; i++) begin
         h_de[i]   = 1'b0;
         h_ctrl[i] = 2'b00;
         h_data[i] = 8'h00;
      end
   endtask

   // drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic step(input logic de, input logic [1:0] c, input logic [7:0] d);
      de_in      = de;
      control_in = c;
      data_in    = d;
      for (int i = 2; i > 0; i--) begin
         h_de[i]   = h_de[i-1];
         h_ctrl[i] = h_ctrl[i-1];
         h_data[i] = h_data[i-1];
      end
      h_de[0]   = de;
      h_ctrl[0] = c;
      h_data[0] = d;
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_in   = 1'b0;
      de_in      = 1'b0;
      control_in = 2'b00;
      data_in    = 8'h00;
`ifdef TMDS_BIST_EN
      bist_in    = 1'b0;
`endif
      clear_hist();

      // reset state
      repeat (2) @(posedge clk_in);
      #1;
      chk10("rst_sym", tmds0, S_C00);
      chk2 ("rst_per", per0, 2'd0);
      chk10("rst_sym_ch1", tmds1, S_C00);
      rst_n_in = 1'b1;
      step(1'b0, 2'b00, 8'h00);
      chk10("post_rst_sym", tmds0, S_C00);
      chk2 ("post_rst_per", per0, 2'd0);

      // control sweep, GUARD_LEN+1 latency
      step(1'b0, 2'b01, 8'h00);
      step(1'b0, 2'b01, 8'h00);
      chk10("ctrl01_latency", tmds0, S_C00);
      step(1'b0, 2'b01, 8'h00);
      chk10("ctrl01", tmds0, S_C01);
      repeat (3) step(1'b0, 2'b10, 8'h00);
      chk10("ctrl10", tmds0, S_C10);
      repeat (3) step(1'b0, 2'b11, 8'h00);
      chk10("ctrl11", tmds0, S_C11);
      chk10("ctrl11_ch1", tmds1, S_C11);
      repeat (10) step(1'b0, 2'b00, 8'h00);
      chk10("blank_sym", tmds0, S_C00);
      chk2 ("blank_per", per0, 2'd0);

      // video with data 0x00: two guard symbols, then video
      step(1'b1, 2'b00, 8'h00);
      chk10("guard1", tmds0, S_G02);
      chk2 ("guard1_per", per0, 2'd1);
      chk10("guard1_ch1", tmds1, S_G1);
      step(1'b1, 2'b00, 8'h00);
      chk10("guard2", tmds0, S_G02);
      step(1'b1, 2'b00, 8'h00);
      chk10("vid0_first", tmds0, 10'b0100000000);
      chk2 ("vid0_per", per0, 2'd2);
      step(1'b1, 2'b00, 8'h00);
      chk10("vid0_second", tmds0, 10'b1111111111);

      // one-cycle blank between video runs
      step(1'b0, 2'b00, 8'h00);
      chk10("vid0_third", tmds0, 10'b0100000000);
      step(1'b1, 2'b00, 8'h00);
      chk10("vid0_fourth", tmds0, 10'b1111111111);
      step(1'b1, 2'b00, 8'h00);
      chk10("short_guard", tmds0, S_G02);
      chk2 ("short_guard_per", per0, 2'd1);
      step(1'b1, 2'b00, 8'h00);
      chk10("after_short_guard", tmds0, 10'b0100000000);
      step(1'b1, 2'b00, 8'h00);
      chk10("after_short_guard2", tmds0, 10'b1111111111);

      // 0xFF against positive and negative disparity
      step(1'b1, 2'b00, 8'hFF);
      chk10("pre_ff_a", tmds0, 10'b0100000000);
      step(1'b1, 2'b00, 8'hFF);
      chk10("pre_ff_b", tmds0, 10'b1111111111);
      step(1'b1, 2'b00, 8'hFF);
      chk10("ff_cnt_pos", tmds0, 10'b1000000000);
      step(1'b1, 2'b00, 8'hFF);
      chk10("ff_cnt_neg", tmds0, 10'b0011111111);

      // asynchronous reset in the middle of video
      rst_n_in = 1'b0;
      #1;
      chk10("midrst_sym", tmds0, S_C00);
      chk2 ("midrst_per", per0, 2'd0);
      clear_hist();
      de_in   = 1'b1;
      data_in = 8'h00;
      @(posedge clk_in);
      #1;
      chk10("midrst_hold", tmds0, S_C00);
      rst_n_in = 1'b1;
      step(1'b1, 2'b00, 8'h00);
      chk10("midrst_guard1", tmds0, S_G02);
      step(1'b1, 2'b00, 8'h00);
      chk10("midrst_guard2", tmds0, S_G02);
      step(1'b1, 2'b00, 8'h00);
      chk10("midrst_vid_first", tmds0, 10'b0100000000);
      step(1'b1, 2'b00, 8'h00);
      chk10("midrst_vid_second", tmds0, 10'b1111111111);

      // settle into control, then random stream
      repeat (3) step(1'b0, 2'b00, 8'h00);
      chk2("pre_rand_per", per0, 2'd0);
      disp     = 0;
      cur_de   = 1'b0;
      run_left = 0;
      for (int i = 0; i < 10000; i++) begin
         if (run_left == 0) begin
            cur_de   = ~cur_de;
            run_left = cur_de ? $urandom_range(1, 40) : $urandom_range(1, 6);
         end
         run_left--;
         step(cur_de, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         if (h_de[2]) exp_per = 2'd2;
         else if (h_de[1] || h_de[0]) exp_per = 2'd1;
         else exp_per = 2'd0;
         chk2("rnd_per", per0, exp_per);
         chk2("rnd_per_ch1", per1, exp_per);
         case (exp_per)
            2'd0: begin
               chk10("rnd_ctrl", tmds0, ctrl_sym(h_ctrl[2]));
               chk10("rnd_ctrl_ch1", tmds1, ctrl_sym(h_ctrl[2]));
               disp = 0;
            end
            2'd1: begin
               chk10("rnd_guard", tmds0, S_G02);
               chk10("rnd_guard_ch1", tmds1, S_G1);
               disp = 0;
            end
            default: begin
               chk8("rnd_decode", decode(tmds0), h_data[2]);
               chk8("rnd_decode_ch1", decode(tmds1), h_data[2]);
               disp = disp + sym_disp(tmds0);
               chk_rng("rnd_disp", disp, -16, 15);
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
